ram_bus_master: RTL and testbench

Bus initiator that drives a 16x8 single-port RAM over its shared bidirectional data bus (cs / wr_en / out_en / address / inout data). Accepts single-word read/write requests from a user-side valid/ready port and sequences the RAM control pins. Owns bus turnaround and captures read data. Sits between processing logic and the RAM instance, and is the only driver of the RAM control pins.

---
 rtl/ram_bus_master.sv | 94 +++++++++
 tb/tb_ram_bus_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// ram_bus_master: sequences a 16x8 single-port RAM over a shared tri-state data bus
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_req_valid/o_req_ready/i_req_wr/i_req_addr/i_req_wdata : user request port
//   o_rsp_valid/o_rsp_rdata[/o_rsp_err]                     : response port
//   o_cs/o_wr_en/o_out_en/o_address_out/io_data_inout        : RAM pins
// Optional: RAM_MASTER_VERIFY_EN adds a read-back after each write and o_rsp_err.
module ram_bus_master #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_wr,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_rdata,
`ifdef RAM_MASTER_VERIFY_EN
   output logic              o_rsp_err,
`endif
   output logic              o_cs,
   output logic              o_wr_en,
   output logic              o_out_en,
   output logic [ADDR_W-1:0] o_address_out,
   inout  wire  [DATA_W-1:0] io_data_inout
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WRITE   = 3'd1;
   localparam logic [2:0] S_RD_ADDR = 3'd2;
   localparam logic [2:0] S_RD_DATA = 3'd3;
   localparam logic [2:0] S_TURN    = 3'd4;
`ifdef RAM_MASTER_VERIFY_EN
   localparam logic [2:0] S_AFTER_WR = S_RD_ADDR;
   logic              r_wr;
`else
   localparam logic [2:0] S_AFTER_WR = S_IDLE;
`endif
   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [DATA_W-1:0] r_wdata;
   logic              w_accept;

   assign o_req_ready = (r_state == S_IDLE) && !i_rst;
   assign w_accept    = i_req_valid && o_req_ready;
   // wr_en is registered and high only in WRITE, so it doubles as the bus drive enable
   assign io_data_inout = o_wr_en ? r_wdata : {DATA_W{1'bz}};

   always_comb begin
      w_next = (r_state == S_IDLE)    ? (w_accept ? (i_req_wr ? S_WRITE : S_RD_ADDR) : S_IDLE) :
               (r_state == S_WRITE)   ? S_AFTER_WR :
               (r_state == S_RD_ADDR) ? S_RD_DATA :
               (r_state == S_RD_DATA) ? S_TURN : S_IDLE;
   end

   // pins are decoded from the next state so they change together with the state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         o_cs          <= 1'b0;
         o_wr_en       <= 1'b0;
         o_out_en      <= 1'b0;
         o_address_out <= '0;
         r_wdata       <= '0;
         o_rsp_valid   <= 1'b0;
         o_rsp_rdata   <= '0;
`ifdef RAM_MASTER_VERIFY_EN
         r_wr          <= 1'b0;
         o_rsp_err     <= 1'b0;
`endif
      end else begin
         r_state     <= w_next;
         o_cs        <= (w_next == S_WRITE) || (w_next == S_RD_ADDR) || (w_next == S_RD_DATA);
         o_wr_en     <= w_next == S_WRITE;
         o_out_en    <= w_next == S_RD_DATA;
         o_rsp_valid <= w_next == S_TURN;
         if (w_accept) begin
            o_address_out <= i_req_addr;
            r_wdata       <= i_req_wdata;
`ifdef RAM_MASTER_VERIFY_EN
            r_wr          <= i_req_wr;
`endif
         end
         if (r_state == S_RD_DATA) begin
            o_rsp_rdata <= io_data_inout;
`ifdef RAM_MASTER_VERIFY_EN
            o_rsp_err   <= r_wr && (io_data_inout != r_wdata);
`endif
         end
      end
   end
endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master: directed + random checks of ram_bus_master against a RAM model and a reference memory
module tb_ram_bus_master;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_wr = 1'b0;
   logic [3:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       req_ready, rsp_valid, cs, wr_en, out_en;
   logic [7:0] rsp_rdata;
   logic [3:0] address_out;
   wire  [7:0] bus;
`ifdef RAM_MASTER_VERIFY_EN
   logic       rsp_err;
   localparam logic [7:0] MASK = 8'hFB;
`else
   localparam logic [7:0] MASK = 8'hFF;
`endif
   logic [7:0] mem [16];
   logic [7:0] ram_q;
   logic [7:0] ref_mem [16];
   logic       prev_oe = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         contention = 0;

   always #5 clk = ~clk;

   ram_bus_master dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
`ifdef RAM_MASTER_VERIFY_EN
      .o_rsp_err(rsp_err),
`endif
      .o_cs(cs), .o_wr_en(wr_en), .o_out_en(out_en),
      .o_address_out(address_out), .io_data_inout(bus)
   );

   // RAM model: synchronous write, registered output, bus driven while selected with out_en
   assign bus = (cs && out_en) ? ram_q : 8'bz;
   always @(posedge clk) begin
      if (cs && wr_en) mem[address_out] <= bus & MASK;
      else if (cs) ram_q <= mem[address_out];
   end

   // the master drives only in WRITE (wr_en=1): flag overlap with out_en now or one cycle earlier
   always @(negedge clk) begin
      if (wr_en && (out_en || prev_oe)) contention++;
      prev_oe <= out_en;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // presents a request from an idle negedge; returns at the negedge of the first busy cycle
   task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d);
      chk("ready_idle", {31'd0, req_ready}, 1);
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_wr = 1'($urandom); req_addr = 4'($urandom); req_wdata = 8'($urandom);
      @(negedge clk);
   endtask

   task automatic finish_read(input logic [3:0] a, input logic [7:0] exp, input logic exp_err);
      chk("rdaddr_cs", {31'd0, cs}, 1);
      chk("rdaddr_wr", {31'd0, wr_en}, 0);
      chk("rdaddr_oe", {31'd0, out_en}, 0);
      chk("rdaddr_addr", {28'd0, address_out}, {28'd0, a});
      chk("rdaddr_ready", {31'd0, req_ready}, 0);
      chk("rdaddr_rv", {31'd0, rsp_valid}, 0);
      @(negedge clk);
      chk("rddata_cs", {31'd0, cs}, 1);
      chk("rddata_oe", {31'd0, out_en}, 1);
      chk("rddata_wr", {31'd0, wr_en}, 0);
      chk("rddata_rv", {31'd0, rsp_valid}, 0);
      @(negedge clk);
      chk("turn_cs", {31'd0, cs}, 0);
      chk("turn_oe", {31'd0, out_en}, 0);
      chk("turn_rv", {31'd0, rsp_valid}, 1);
      chk("turn_rdata", {24'd0, rsp_rdata}, {24'd0, exp});
`ifdef RAM_MASTER_VERIFY_EN
      chk("turn_err", {31'd0, rsp_err}, {31'd0, exp_err});
`endif
      @(negedge clk);
      chk("post_rv", {31'd0, rsp_valid}, 0);
      chk("post_ready", {31'd0, req_ready}, 1);
      chk("post_rdata_held", {24'd0, rsp_rdata}, {24'd0, exp});
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      issue(1'b1, a, d);
      chk("wr_cs", {31'd0, cs}, 1);
      chk("wr_we", {31'd0, wr_en}, 1);
      chk("wr_oe", {31'd0, out_en}, 0);
      chk("wr_addr", {28'd0, address_out}, {28'd0, a});
      chk("wr_ready", {31'd0, req_ready}, 0);
      chk("wr_bus", {24'd0, bus}, {24'd0, d});
      ref_mem[a] = d & MASK;
      @(negedge clk);
`ifdef RAM_MASTER_VERIFY_EN
      finish_read(a, ref_mem[a], ref_mem[a] != d);
`else
      chk("wr_done_cs", {31'd0, cs}, 0);
      chk("wr_done_we", {31'd0, wr_en}, 0);
      chk("wr_done_rv", {31'd0, rsp_valid}, 0);
      chk("wr_done_ready", {31'd0, req_ready}, 1);
`endif
   endtask

   task automatic do_read(input logic [3:0] a);
      issue(1'b0, a, 8'h00);
      finish_read(a, ref_mem[a], 1'b0);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_cs", {31'd0, cs}, 0);
      chk("rst_we", {31'd0, wr_en}, 0);
      chk("rst_oe", {31'd0, out_en}, 0);
      chk("rst_addr", {28'd0, address_out}, 0);
      chk("rst_rv", {31'd0, rsp_valid}, 0);
      chk("rst_rdata", {24'd0, rsp_rdata}, 0);
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'd0, req_ready}, 1);
      @(negedge clk);
      for (int i = 0; i < 16; i++) do_write(4'(i), 8'($urandom));
      do_write(4'd3, 8'hA5);
      do_read(4'd3);
      do_write(4'd15, 8'h3C);
      do_write(4'd0, 8'hC3);
      do_read(4'd15);
      do_read(4'd0);
      do_read(4'd7);
      do_write(4'd7, 8'h11);
      do_read(4'd7);
      // request held through a busy read; a write shown mid-transaction must be ignored
      chk("hold_ready0", {31'd0, req_ready}, 1);
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd5;
      @(posedge clk);
      #1;
      req_wr = 1'b1; req_addr = 4'd9; req_wdata = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_busy", {31'd0, req_ready}, 0);
         chk("hold_addr", {28'd0, address_out}, 5);
      end
      chk("hold_turn_rv", {31'd0, rsp_valid}, 1);
      chk("hold_turn_rdata", {24'd0, rsp_rdata}, {24'd0, ref_mem[5]});
      req_wr = 1'b0;
      @(negedge clk);
      chk("hold_idle_ready", {31'd0, req_ready}, 1);
      chk("hold_idle_cs", {31'd0, cs}, 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      finish_read(4'd9, ref_mem[9], 1'b0);
      // reset asserted during RD_DATA
      issue(1'b0, 4'd2, 8'h00);
      @(negedge clk);
      chk("abort_pre_oe", {31'd0, out_en}, 1);
      #1 rst = 1'b1;
      #1;
      chk("abort_cs", {31'd0, cs}, 0);
      chk("abort_oe", {31'd0, out_en}, 0);
      chk("abort_addr", {28'd0, address_out}, 0);
      chk("abort_rv", {31'd0, rsp_valid}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_rv", {31'd0, rsp_valid}, 0);
         chk("abort_idle_cs", {31'd0, cs}, 0);
      end
      do_read(4'd2);
`ifdef RAM_MASTER_VERIFY_EN
      do_write(4'd6, 8'h04);
      do_write(4'd6, 8'h01);
`endif
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(1) == 1) do_write(4'($urandom), 8'($urandom));
         else do_read(4'($urandom));
      end
      chk("contention", contention, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
